// File: rtl/instr_stream_pkg.sv
// Shared constants and FSM state type for the instruction stream transmitter.
package instr_stream_pkg;

    localparam logic [7:0] START_MARK = 8'hFE;
    localparam logic [7:0] STOP_MARK  = 8'hFF;
    localparam logic [7:0] IDLE_BYTE  = 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/instr_stream_tx.sv
// Serialises 32-bit instruction words into a framed byte stream (FE, data MSB-first, FF).
// Optional INSTR_STREAM_TX_FF_CHECK_EN: data bytes equal to 0xFF are sent as 0x00 and flag err_o.
module instr_stream_tx
    import instr_stream_pkg::*;
#(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    input  logic        word_last_i,
    output logic        word_ready_o,
    output logic [7:0]  byte_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [6:0]  word_cnt_o
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        room;
    logic        accept;
    logic        send_data;
    logic [31:0] src_word;
    logic [1:0]  src_idx;
    logic [7:0]  raw_byte;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] scrub_byte(input logic [7:0] b);
`ifdef INSTR_STREAM_TX_FF_CHECK_EN
        return (b == STOP_MARK) ? IDLE_BYTE : b;
`else
        return b;
`endif
    endfunction

    assign room         = (cnt_q < MAX_CNT);
    assign word_ready_o = (state_q == START) ||
                          ((state_q == DATA) && (idx_q == 2'd0) && !last_q && room);
    assign accept       = word_valid_i && word_ready_o;
    assign raw_byte     = pick_byte(src_word, src_idx);

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        word_d    = word_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        send_data = 1'b0;
        src_word  = word_q;
        src_idx   = idx_q - 2'd1;

        case (state_q)
            IDLE: begin
                byte_d = IDLE_BYTE;
                if (start_i) begin
                    state_d = START;
                    byte_d  = START_MARK;
                    cnt_d   = 7'd0;
                    err_d   = 1'b0;
                    last_d  = 1'b0;
                    idx_d   = 2'd0;
                end
            end
            START, DATA: begin
                if (state_q == DATA && idx_q != 2'd0) begin
                    send_data = 1'b1;
                    idx_d     = idx_q - 2'd1;
                end else if (accept) begin
                    // New word goes straight onto the wire so consecutive words have no gap
                    state_d   = DATA;
                    word_d    = word_i;
                    last_d    = word_last_i;
                    idx_d     = 2'd3;
                    cnt_d     = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 7'd1;
                    send_data = 1'b1;
                    src_word  = word_i;
                    src_idx   = 2'd3;
                end else begin
                    // Empty load, underrun and overflow all end here without a last word
                    state_d = STOP;
                    byte_d  = STOP_MARK;
                    if (state_q == START || !last_q) err_d = 1'b1;
                end
            end
            STOP: begin
                state_d = DONE;
                byte_d  = IDLE_BYTE;
            end
            DONE: begin
                state_d = IDLE;
                byte_d  = IDLE_BYTE;
            end
            default: begin
                state_d = IDLE;
                byte_d  = IDLE_BYTE;
            end
        endcase

        if (send_data) begin
            byte_d = scrub_byte(raw_byte);
`ifdef INSTR_STREAM_TX_FF_CHECK_EN
            if (raw_byte == STOP_MARK) err_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q  <= IDLE_BYTE;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            last_q  <= 1'b0;
            cnt_q   <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign byte_o     = byte_q;
    assign busy_o     = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;
    assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_stream_tx.sv
// Bench for instr_stream_tx: frame model builds the expected byte stream per load; a negedge process compares.
module tb_instr_stream_tx;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_last_i;
    logic        word_ready_o;
    logic [7:0]  byte_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [6:0]  word_cnt_o;

    instr_stream_tx #(.MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_last_i  (word_last_i),
        .word_ready_o (word_ready_o),
        .byte_o       (byte_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  cap_q[$];
    logic        armed = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] prog[8];
    logic        exp_err;
    int          exp_cnt;
    int          exp_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Frame model: words accepted while valid is held, capped by capacity; err on short/overflow/0xFF.
    task automatic build_model(input int n, input int drop_at);
        int a;
        logic ff;
        logic [7:0] b;
        a  = n;
        if (drop_at < a) a = drop_at;
        if (a > MAXW) a = MAXW;
        ff = 1'b0;
        exp_q.delete();
        exp_q.push_back('{8'hFE, 1'b1, 1'b0});
        for (int i = 0; i < a; i++) begin
            for (int j = 3; j >= 0; j--) begin
                b = prog[i][8*j +: 8];
`ifdef INSTR_STREAM_TX_FF_CHECK_EN
                if (b == 8'hFF) begin
                    b  = 8'h00;
                    ff = 1'b1;
                end
`endif
                exp_q.push_back('{b, 1'b1, 1'b0});
            end
        end
        exp_q.push_back('{8'hFF, 1'b1, 1'b0});
        exp_q.push_back('{8'h00, 1'b0, 1'b1});
        exp_q.push_back('{8'h00, 1'b0, 1'b0});
        exp_err = (a < n) || ff;
        exp_cnt = a;
        exp_acc = a;
    endtask

    always @(negedge clk) begin
        if (armed && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cap_q.push_back(byte_o);
            chk("byte_o", {24'd0, byte_o}, {24'd0, e.b});
            chk("busy_o", {31'd0, busy_o}, {31'd0, e.busy});
            chk("done_o", {31'd0, done_o}, {31'd0, e.done});
        end
    end

    task automatic set_inputs(input int k, input int n, input int drop_at);
        word_valid_i = (k < n) && (k < drop_at);
        word_i       = (k < n) ? prog[k] : 32'd0;
        word_last_i  = (k == n - 1);
    endtask

    task automatic run_load(input int n, input int drop_at);
        int  k;
        int  cycles;
        logic acc;
        build_model(n, drop_at);
        cap_q.delete();
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        armed   = 1'b1;
        k = 0;
        cycles = 0;
        set_inputs(k, n, drop_at);
        while (exp_q.size() > 0 && cycles < 300) begin
            @(negedge clk);
            acc = word_valid_i && word_ready_o;
            @(posedge clk); #1;
            if (acc) k++;
            cycles++;
            set_inputs(k, n, drop_at);
            // A start request mid-load must be ignored
            start_i = (cycles == 2) && (exp_acc >= 1);
        end
        start_i = 1'b0;
        armed   = 1'b0;
        if (exp_q.size() > 0) chk("load_timeout", 32'(exp_q.size()), 32'd0);
        chk("err_o", {31'd0, err_o}, {31'd0, exp_err});
        chk("word_cnt_o", {25'd0, word_cnt_o}, 32'(exp_cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte"},  {24'd0, byte_o},       32'd0);
        chk({tag, "_ready"}, {31'd0, word_ready_o}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy_o},       32'd0);
        chk({tag, "_done"},  {31'd0, done_o},       32'd0);
        chk({tag, "_err"},   {31'd0, err_o},        32'd0);
        chk({tag, "_cnt"},   {25'd0, word_cnt_o},   32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start_i      = 1'b0;
        word_i       = 32'd0;
        word_valid_i = 1'b0;
        word_last_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        // Empty load: FE then FF, error
        prog[0] = 32'hDEADBEEF;
        run_load(1, 0);
        chk("empty_len_fe", {24'd0, cap_q[0]}, 32'hFE);
        chk("empty_len_ff", {24'd0, cap_q[1]}, 32'hFF);

        // Single word, clears previous error
        prog[0] = 32'h00500093;
        run_load(1, 99);
        chk("one_b0", {24'd0, cap_q[0]}, 32'hFE);
        chk("one_b1", {24'd0, cap_q[1]}, 32'h00);
        chk("one_b2", {24'd0, cap_q[2]}, 32'h50);
        chk("one_b3", {24'd0, cap_q[3]}, 32'h00);
        chk("one_b4", {24'd0, cap_q[4]}, 32'h93);
        chk("one_b5", {24'd0, cap_q[5]}, 32'hFF);

        // Three back-to-back words
        prog[0] = 32'h11223344;
        prog[1] = 32'h55667788;
        prog[2] = 32'h99AABBCC;
        run_load(3, 99);
        chk("three_b5",  {24'd0, cap_q[5]},  32'h55);
        chk("three_b12", {24'd0, cap_q[12]}, 32'hCC);
        chk("three_b13", {24'd0, cap_q[13]}, 32'hFF);

        // Underrun after first of two words
        prog[0] = 32'hA1B2C3D4;
        prog[1] = 32'h01020304;
        run_load(2, 1);
        chk("under_b4", {24'd0, cap_q[4]}, 32'hD4);
        chk("under_b5", {24'd0, cap_q[5]}, 32'hFF);

        // 0xFF data byte
        prog[0] = 32'h12FF3456;
        run_load(1, 99);
`ifdef INSTR_STREAM_TX_FF_CHECK_EN
        chk("ff_b2",  {24'd0, cap_q[2]}, 32'h00);
        chk("ff_err", {31'd0, err_o},    32'd1);
`else
        chk("ff_b2",  {24'd0, cap_q[2]}, 32'hFF);
        chk("ff_err", {31'd0, err_o},    32'd0);
`endif

        // Overflow: 5 words with capacity 4
        prog[0] = 32'h10203040;
        prog[1] = 32'h50607080;
        prog[2] = 32'h90A0B0C0;
        prog[3] = 32'hD0E0F001;
        prog[4] = 32'h02030405;
        run_load(5, 99);
        chk("ovf_b16",  {24'd0, cap_q[16]}, 32'h01);
        chk("ovf_b17",  {24'd0, cap_q[17]}, 32'hFF);
        chk("ovf_cnt",  {25'd0, word_cnt_o}, 32'd4);
        chk("ovf_err",  {31'd0, err_o},      32'd1);

        // Exactly capacity words, last flagged: no error
        run_load(4, 99);
        chk("full_err", {31'd0, err_o}, 32'd0);

        // Reset asserted during DATA
        prog[0] = 32'hCAFEF00D;
        prog[1] = 32'h0BADBEEF;
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        set_inputs(0, 2, 99);
        @(posedge clk); #1;
        set_inputs(1, 2, 99);
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1 check_reset_outputs("async");
        word_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_byte", {24'd0, byte_o}, 32'h00);

        prog[0] = 32'h0F1E2D3C;
        prog[1] = 32'h4B5A6978;
        run_load(2, 99);
        chk("clean_b0", {24'd0, cap_q[0]}, 32'hFE);
        chk("clean_b9", {24'd0, cap_q[9]}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
